// File: rtl/assoc_cache_pkg.sv
// Shared types for the set-associative cache: controller state encoding and per-way line metadata.
// Tags are held in a fixed 32-bit field so the struct is independent of the index/offset split.
package assoc_cache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } state_t;

    typedef struct packed {
        logic        valid;
        logic        dirty;
        logic [31:0] tag;
    } way_meta_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (lanes[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/assoc_cache_way.sv
// One cache way: line data and metadata arrays with combinational lookup and hit compare.
// Latency: reads are combinational on index/word_sel; writes land on the next rising edge.
// Backpressure: none, the controller sequences all accesses.
module assoc_cache_way
    import assoc_cache_pkg::*;
#(
    parameter int OFFSET_BITS = 5,
    parameter int INDEX_BITS  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INDEX_BITS-1:0]   index,
    input  logic [OFFSET_BITS-3:0]  word_sel,
    input  logic [31:0]             tag,
    output logic [31:0]             rd_data,
    output way_meta_t               meta,
    output logic                    hit,
    input  logic                    data_we,
    input  logic [OFFSET_BITS-3:0]  data_word,
    input  logic [31:0]             data_wdata,
    input  logic [3:0]              data_be,
    input  logic                    meta_we,
    input  way_meta_t               meta_wdata
);

    localparam int SETS  = 1 << INDEX_BITS;
    localparam int WORDS = 1 << (OFFSET_BITS - 2);

    logic [31:0] data_q [SETS][WORDS];
    way_meta_t   meta_q [SETS];

    assign meta    = meta_q[index];
    assign hit     = meta.valid && (meta.tag == tag);
    assign rd_data = data_q[index][word_sel];

    // Line data carries no reset; only the metadata decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (data_we) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be[b]) data_q[index][data_word][8*b +: 8] <= data_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) meta_q[s] <= '0;
        end else if (meta_we) begin
            meta_q[index] <= meta_wdata;
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// Write-back, write-allocate set-associative cache; ASSOC_CACHE_STATS_EN adds hit/miss counters.
// Latency: hit completes 2 cycles after accept; miss adds 1 + one cycle per acknowledged memory beat.
// Backpressure: CPU strobes are held until cpu_valid; memory stalls a beat by withholding mem_valid.
module assoc_cache
    import assoc_cache_pkg::*;
#(
    parameter int OFFSET_BITS = 5,
    parameter int INDEX_BITS  = 3,
    parameter int WAYS        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byte_en,
    output logic [31:0] cpu_rdata,
    output logic        cpu_valid,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strobe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
`ifdef ASSOC_CACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int WORD_BITS = OFFSET_BITS - 2;
    localparam int SETS      = 1 << INDEX_BITS;
    localparam int TAG_W     = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t state, state_nxt;

    logic [31:0]          req_addr, req_wdata;
    logic [3:0]           req_be;
    logic                 req_write;
    logic [WORD_BITS-1:0] beat;
    logic [WAY_BITS-1:0]  vict_q, vict_sel, rr_next;
    logic [WAY_BITS-1:0]  rr_q [SETS];

    logic [INDEX_BITS-1:0] req_idx;
    logic [WORD_BITS-1:0]  req_word, way_word_sel, data_word;
    logic [31:0]           req_tag, data_wdata, hit_word;
    logic [3:0]            data_be;
    way_meta_t             meta_wdata;

    logic [WAYS-1:0] way_hit, way_dwe, way_mwe;
    logic [31:0]     way_rdata [WAYS];
    way_meta_t       way_meta  [WAYS];

    logic accept, any_hit, vict_dirty, in_burst, fill_beat, fill_done, write_hit;
    logic unused_addr_bits;

    assign req_idx  = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_word = req_addr[2 +: WORD_BITS];
    assign req_tag  = 32'(req_addr[31:INDEX_BITS+OFFSET_BITS]);
    assign unused_addr_bits = ^req_addr[1:0];

    assign accept    = (state == IDLE) && (cpu_read || cpu_write) && !cpu_valid;
    assign in_burst  = (state == WRITEBACK) || (state == ALLOCATE);
    assign fill_beat = (state == ALLOCATE) && mem_valid;
    assign fill_done = fill_beat && (&beat);
    assign write_hit = (state == COMPARE) && req_write;

    assign way_word_sel = (state == WRITEBACK) ? beat : req_word;
    assign data_word    = (state == ALLOCATE) ? beat : req_word;
    assign data_wdata   = (state == ALLOCATE) ? mem_rdata : req_wdata;
    assign data_be      = (state == ALLOCATE) ? 4'hF : req_be;

    always_comb begin
        meta_wdata       = '0;
        meta_wdata.valid = 1'b1;
        meta_wdata.dirty = (state != ALLOCATE);
        meta_wdata.tag   = req_tag;
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_dwe[w] = (write_hit && way_hit[w]) || (fill_beat && (vict_q == WAY_BITS'(w)));
        assign way_mwe[w] = (write_hit && way_hit[w]) || (fill_done && (vict_q == WAY_BITS'(w)));

        assoc_cache_way #(
            .OFFSET_BITS (OFFSET_BITS),
            .INDEX_BITS  (INDEX_BITS)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .index      (req_idx),
            .word_sel   (way_word_sel),
            .tag        (req_tag),
            .rd_data    (way_rdata[w]),
            .meta       (way_meta[w]),
            .hit        (way_hit[w]),
            .data_we    (way_dwe[w]),
            .data_word  (data_word),
            .data_wdata (data_wdata),
            .data_be    (data_be),
            .meta_we    (way_mwe[w]),
            .meta_wdata (meta_wdata)
        );
    end

    always_comb begin
        any_hit  = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) begin
                any_hit  = 1'b1;
                hit_word = way_rdata[w];
            end
        end
    end

    // Lowest-numbered empty way wins; otherwise fall back to the set's rotating pointer.
    always_comb begin
        vict_sel = rr_q[req_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_meta[w].valid) vict_sel = WAY_BITS'(w);
        end
    end

    assign vict_dirty = way_meta[vict_sel].valid && way_meta[vict_sel].dirty;
    assign rr_next    = (rr_q[req_idx] == WAY_BITS'(WAYS - 1)) ? '0 : rr_q[req_idx] + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = COMPARE;
            COMPARE:   state_nxt = any_hit ? IDLE : (vict_dirty ? WRITEBACK : ALLOCATE);
            WRITEBACK: if (mem_valid && (&beat)) state_nxt = ALLOCATE;
            ALLOCATE:  if (mem_valid && (&beat)) state_nxt = COMPARE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_strobe = '0;
        case (state)
            WRITEBACK: begin
                mem_write  = 1'b1;
                mem_strobe = 4'hF;
                mem_addr   = {way_meta[vict_q].tag[TAG_W-1:0], req_idx, beat, 2'b00};
                mem_wdata  = way_rdata[vict_q];
            end
            ALLOCATE: begin
                mem_read = 1'b1;
                mem_addr = {req_addr[31:OFFSET_BITS], beat, 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
            req_write <= 1'b0;
            beat      <= '0;
            vict_q    <= '0;
            cpu_valid <= 1'b0;
            cpu_rdata <= '0;
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else begin
            if (accept) begin
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
                req_be    <= cpu_byte_en;
                req_write <= cpu_write;
            end
            cpu_valid <= (state == COMPARE) && any_hit;
            cpu_rdata <= ((state == COMPARE) && any_hit) ? hit_word : '0;
            if ((state == COMPARE) && !any_hit) vict_q <= vict_sel;
            if (in_burst && mem_valid) beat <= beat + 1'b1;
            if (fill_done) rr_q[req_idx] <= rr_next;
        end
    end

`ifdef ASSOC_CACHE_STATS_EN
    // The compare that follows a refill is the same request, so it must not count as a hit.
    logic retry_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            retry_q    <= 1'b0;
        end else begin
            if (fill_done) retry_q <= 1'b1;
            else if (state == COMPARE) retry_q <= 1'b0;
            if ((state == COMPARE) && any_hit && !retry_q && (hit_count != 32'hFFFF_FFFF))
                hit_count <= hit_count + 32'd1;
            if ((state == COMPARE) && !any_hit && (miss_count != 32'hFFFF_FFFF))
                miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 SHALL have parameter OFFSET_BITS, 5, byte-offset width; line = 2**OFFSET_BITS bytes, WORDS = line/4.
REQ-002 SHALL have parameter INDEX_BITS, 3, set-index width; SETS = 2**INDEX_BITS.
REQ-003 SHALL have parameter WAYS, 2, associativity; legal values 1, 2, 4.
REQ-004 SHALL have port clk  input  1  system clock; one clock only, all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports cpu_read, cpu_write  input  1 each  CPU request strobes, held until cpu_valid.
REQ-007 SHALL have port cpu_addr  input  32  byte address; tag = upper 32-INDEX_BITS-OFFSET_BITS bits.
REQ-008 SHALL have ports cpu_wdata  input  32, cpu_byte_en  input  4  write word and byte lanes.
REQ-009 SHALL have ports cpu_rdata  output  32, cpu_valid  output  1  read word and one-cycle completion pulse.
REQ-010 SHALL have ports mem_read, mem_write  output  1 each  memory beat requests.
REQ-011 SHALL have ports mem_addr  output  32, mem_wdata  output  32, mem_strobe  output  4  beat address, data, lanes.
REQ-012 SHALL have ports mem_rdata  input  32, mem_valid  input  1  beat data and per-beat acknowledge.

Function
REQ-013 SHALL implement FSM IDLE -> COMPARE -> (hit: IDLE) | (miss, victim dirty: WRITEBACK -> ALLOCATE) | (miss, victim clean: ALLOCATE); ALLOCATE -> COMPARE.
REQ-014 SHALL latch address, wdata, byte_en, op in IDLE when cpu_read or cpu_write is high; both high is treated as write.
REQ-015 SHALL, on a hit in COMPARE, pulse cpu_valid for exactly one cycle (2 cycles after request accept) with cpu_rdata = addressed word.
REQ-016 SHALL, on a write hit, merge cpu_wdata into the line per cpu_byte_en and set the way's dirty bit; memory is untouched.
REQ-017 SHALL select victim as lowest-index invalid way, else the set's round-robin pointer; pointer advances mod WAYS on each allocate.
REQ-018 SHALL, in WRITEBACK, hold mem_write=1, mem_strobe=4'hF, mem_addr = {victim tag, index, beat, 2'b00}, advancing beat on each mem_valid; exit after beat WORDS-1.
REQ-019 SHALL, in ALLOCATE, hold mem_read=1 with mem_addr = {request tag, index, beat, 2'b00}, storing mem_rdata on each mem_valid; after last beat set valid=1, dirty=0, tag.
REQ-020 SHALL never assert mem_read and mem_write in the same cycle; both are low in IDLE and COMPARE.
REQ-021 SHALL ignore mem_valid outside WRITEBACK/ALLOCATE.
REQ-022 SHALL treat a miss retry after ALLOCATE as a guaranteed hit (total miss latency = 3 + beats acknowledged).

Reset
REQ-023 SHALL, on rst assertion at any time (including mid-burst), enter IDLE, clear all valid, dirty and round-robin pointers and the beat counter; dirty data is discarded.
REQ-024 SHALL drive cpu_valid=0, cpu_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_strobe=0 while in reset.
REQ-025 SHALL leave data arrays uninitialised; only metadata is reset.

Configuration
REQ-026 SHALL, with ASSOC_CACHE_STATS_EN defined, add outputs hit_count and miss_count (32 bits each), incremented in COMPARE on hit/miss (miss counted once per request), saturating at 32'hFFFFFFFF, cleared by rst.
REQ-027 SHALL, without ASSOC_CACHE_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, COMPARE, WRITEBACK, ALLOCATE) and the per-way metadata struct (valid, dirty, tag) in package assoc_cache_pkg.
REQ-029 SHALL instantiate one sub-module assoc_cache_way per way (tag/valid/dirty/data arrays, hit compare); control and victim selection stay in assoc_cache.

Verification
REQ-030 SHALL cover cold read 0x0000_0040 with memory returning word i = 0xA000_0000+i: 8 read beats at 0x40..0x5C, cpu_rdata=0xA000_0000, miss_count=1.
REQ-031 SHALL cover repeat read 0x0000_0044: cpu_valid 2 cycles after request, cpu_rdata=0xA000_0001, no mem activity, hit_count=1.
REQ-032 SHALL cover write 0x0000_0044 data 0x1234_5678 byte_en 4'b0011 then read: cpu_rdata=0xA000_5678, dirty set.
REQ-033 SHALL cover three tags 0x000,0x400,0x800 mapping to set 2 (WAYS=2): third access writes back dirty way 0 (8 write beats at old address) before allocating.
REQ-034 SHALL cover rst asserted at beat 3 of ALLOCATE: mem_read low immediately, subsequent read of same address misses and refetches all 8 beats.
